pmod_pattern_checker: RTL and testbench
=======================================

# pmod_pattern_checker

Receive-side companion to the PMOD differential pattern outputs: samples a WIDTH-bit binary counter pattern arriving asynchronously on header input pins (external loopback from the transmitting PMOD lanes), synchronizes and deglitches it, and verifies that each new value is the previous value + 1 modulo 2^WIDTH. It reports lock status, a per-value strobe, and a saturating error count suitable for LEDs or VIO probes in the test-project top level.

## Interface
- WIDTH, 4, number of pattern lanes / counter bits
- SYNC_STAGES, 2, synchronizer flops per lane (>= 2)
- STABLE_CYCLES, 4, consecutive equal synchronized samples required to accept a value (>= 1)
- LOCK_COUNT, 8, consecutive correct increments required to declare lock (>= 1)
- TIMEOUT_CYCLES, 2**24, enabled cycles without an accepted value before a locked checker declares the link stuck
- ERR_WIDTH, 16, width of error counter
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  enable; 0 freezes filter, FSM and timeout counter (synchronizer keeps running)
- in  input  WIDTH  asynchronous pattern lanes from header pins
- clr_err  input  1  synchronous clear of err_count
- value  output  WIDTH  last accepted pattern value
- value_valid  output  1  one-cycle strobe when value updates
- locked  output  1  high while in LOCKED state
- err_pulse  output  1  one-cycle strobe per detected error
- err_count  output  ERR_WIDTH  saturating error count

## Operation
- Synchronizer: SYNC_STAGES flops per lane, reset to 0, always clocked.
- Filter: candidate register plus stability counter. Synchronized word differs from candidate -> candidate loads it, counter restarts. Word held equal for STABLE_CYCLES samples -> accepted if it differs from value, or if no value accepted since reset/HUNT entry. Accepted word loads value, pulses value_valid. Repeated acceptance of the same word is impossible; a pulse shorter than STABLE_CYCLES samples is never accepted.
- FSM states HUNT, TRACK, LOCKED; good counter gcnt; timeout counter tcnt.
- HUNT: first accepted value -> TRACK, gcnt = 0. No errors counted.
- TRACK: accepted value == prev + 1 (mod 2^WIDTH) -> gcnt++; gcnt reaching LOCK_COUNT -> LOCKED. Otherwise gcnt = 0, stay TRACK, no error.
- LOCKED: accepted value == prev + 1 -> stay, tcnt = 0. Any other accepted value -> err_pulse, err_count++, -> TRACK, gcnt = 0 (the bad value becomes new prev).
- LOCKED timeout: tcnt increments each enabled cycle with no acceptance; reaching TIMEOUT_CYCLES -> err_pulse, err_count++, -> HUNT, tcnt = 0. tcnt idle outside LOCKED.
- Wrap 2^WIDTH-1 -> 0 is a correct increment.
- err_count saturates at 2^ERR_WIDTH-1. clr_err coincident with an error: result 0 (clear wins); err_pulse still asserts.
- ena = 0: value_valid and err_pulse held 0, all filter/FSM/counter state frozen.
- rst: all state and outputs to 0, FSM to HUNT, takes priority over everything.

## Timing
- Reset values: value 0, value_valid 0, locked 0, err_pulse 0, err_count 0.
- Latency: value_valid asserts exactly SYNC_STAGES + STABLE_CYCLES cycles after the first rising edge sampling a new stable input (ena = 1).
- locked rises the cycle after the value_valid of the LOCK_COUNT-th consecutive good increment; falls the cycle after the err_pulse that causes exit.
- err_pulse aligned with the cycle the error state change is registered; err_count reflects the increment on the same cycle as err_pulse.
- All outputs registered; no combinational path from in, ena or clr_err to outputs.

## Test plan
- Defaults except TIMEOUT_CYCLES=64: reset, drive 0,1,...,15,0,1 each held 10 cycles -> value_valid per step 6 cycles after change, locked rises after 9th accepted value, stays high across 15->0, err_count = 0.
- Locked at 5, 2-cycle glitch to 0xF, then 6 -> no value_valid for 0xF, value goes 5->6, no err_pulse.
- Locked, sequence 5 then 7 -> single err_pulse, err_count = 1, locked falls; 8 further good increments -> locked returns.
- Locked, hold input constant 70 cycles -> err_pulse at 64 idle cycles, err_count +1, locked 0, FSM HUNT; resume counting -> relock after first value + 8 good increments.
- ERR_WIDTH=2, force 5 skip errors -> err_count = 3 (saturated); clr_err on same cycle as next error -> err_count = 0, err_pulse = 1.
- ena = 0 for 100 cycles while locked -> no timeout, no strobes; rst mid-lock -> all outputs 0 next cycle, full relock sequence required.

Source files
------------

// File: rtl/pmod_pattern_checker.sv
// Receive-side checker for a looped-back binary counter pattern: synchronize,
// deglitch, then verify each accepted value is the previous one plus one.
module pmod_pattern_checker #(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned LOCK_COUNT     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2**24,
   parameter int unsigned ERR_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [WIDTH-1:0]     in,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     value,
   output logic                 value_valid,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count
);

   localparam int unsigned SCNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned GCNT_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_TRACK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]     sync_w;
   logic [WIDTH-1:0]     cand, cand_nxt;
   logic [SCNT_W-1:0]    scnt, scnt_nxt;
   logic                 have, have_nxt;
   logic [1:0]           state, state_nxt;
   logic [GCNT_W-1:0]    gcnt, gcnt_nxt;
   logic [TCNT_W-1:0]    tcnt, tcnt_nxt;
   logic [WIDTH-1:0]     value_nxt;
   logic [WIDTH-1:0]     value_inc;
   logic                 vv_nxt, ep_nxt, accept;
   logic [ERR_WIDTH-1:0] ec_nxt;

   // Lane synchronizer; runs regardless of ena.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_w    = sync_q[SYNC_STAGES-1];
   assign value_inc = WIDTH'(value + WIDTH'(1));

   // Filter, tracking FSM and error bookkeeping: next-state logic.
   always_comb begin
      cand_nxt  = cand;
      scnt_nxt  = scnt;
      have_nxt  = have;
      state_nxt = state;
      gcnt_nxt  = gcnt;
      tcnt_nxt  = tcnt;
      value_nxt = value;
      vv_nxt    = 1'b0;
      ep_nxt    = 1'b0;
      accept    = 1'b0;

      if (ena) begin
         // scnt saturates at STABLE_CYCLES so a held word is judged only once.
         if (sync_w != cand) begin
            cand_nxt = sync_w;
            scnt_nxt = '0;
         end else if (scnt < SCNT_W'(STABLE_CYCLES)) begin
            scnt_nxt = SCNT_W'(scnt + SCNT_W'(1));
            if (scnt == SCNT_W'(STABLE_CYCLES - 1) && (!have || cand != value))
               accept = 1'b1;
         end

         if (accept) begin
            value_nxt = cand;
            have_nxt  = 1'b1;
            vv_nxt    = 1'b1;
         end

         case (state)
            ST_HUNT: begin
               if (accept) begin
                  state_nxt = ST_TRACK;
                  gcnt_nxt  = '0;
               end
            end
            ST_TRACK: begin
               if (accept) begin
                  if (cand == value_inc) begin
                     if (gcnt == GCNT_W'(LOCK_COUNT - 1)) begin
                        state_nxt = ST_LOCKED;
                        gcnt_nxt  = '0;
                        tcnt_nxt  = '0;
                     end else begin
                        gcnt_nxt = GCNT_W'(gcnt + GCNT_W'(1));
                     end
                  end else begin
                     gcnt_nxt = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (accept) begin
                  tcnt_nxt = '0;
                  if (cand != value_inc) begin
                     ep_nxt    = 1'b1;
                     state_nxt = ST_TRACK;
                     gcnt_nxt  = '0;
                  end
               end else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Stuck link: restart acquisition from scratch.
                  ep_nxt    = 1'b1;
                  state_nxt = ST_HUNT;
                  tcnt_nxt  = '0;
                  have_nxt  = 1'b0;
               end else begin
                  tcnt_nxt = TCNT_W'(tcnt + TCNT_W'(1));
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end

      ec_nxt = err_count;
      if (clr_err)
         ec_nxt = '0;
      else if (ep_nxt && err_count != {ERR_WIDTH{1'b1}})
         ec_nxt = ERR_WIDTH'(err_count + ERR_WIDTH'(1));
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand        <= '0;
         scnt        <= '0;
         have        <= 1'b0;
         state       <= ST_HUNT;
         gcnt        <= '0;
         tcnt        <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         err_count   <= '0;
      end else begin
         cand        <= cand_nxt;
         scnt        <= scnt_nxt;
         have        <= have_nxt;
         state       <= state_nxt;
         gcnt        <= gcnt_nxt;
         tcnt        <= tcnt_nxt;
         value       <= value_nxt;
         value_valid <= vv_nxt;
         locked      <= (state == ST_LOCKED);
         err_pulse   <= ep_nxt;
         err_count   <= ec_nxt;
      end
   end

endmodule

// File: tb/tb_pmod_pattern_checker.sv
// Directed bench for pmod_pattern_checker: two instances share stimulus, one
// with a 2-bit error counter to exercise saturation.
module tb_pmod_pattern_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [3:0]  pin;
   logic        clr_err;

   logic [3:0]  value_a, value_b;
   logic        vv_a, vv_b, locked_a, locked_b, ep_a, ep_b;
   logic [15:0] ec_a;
   logic [1:0]  ec_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pmod_pattern_checker #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
      .LOCK_COUNT(8), .TIMEOUT_CYCLES(64), .ERR_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .ena(ena), .in(pin), .clr_err(clr_err),
      .value(value_a), .value_valid(vv_a), .locked(locked_a),
      .err_pulse(ep_a), .err_count(ec_a));

   pmod_pattern_checker #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
      .LOCK_COUNT(8), .TIMEOUT_CYCLES(64), .ERR_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .ena(ena), .in(pin), .clr_err(clr_err),
      .value(value_b), .value_valid(vv_b), .locked(locked_b),
      .err_pulse(ep_b), .err_count(ec_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive v, run 10 cycles; report first value_valid tick and strobe counts.
   task automatic step(input logic [3:0] v, output int lat, output int nvv, output int nep);
      pin = v;
      lat = 0;
      nvv = 0;
      nep = 0;
      for (int t = 1; t <= 10; t++) begin
         @(negedge clk);
         if (vv_a) begin
            nvv++;
            if (lat == 0) lat = t;
         end
         if (ep_a) nep++;
      end
   endtask

   initial begin
      logic [3:0] cur;
      int lat, nvv, nep, seen, ep_tick, acc;

      rst = 1'b1; ena = 1'b1; pin = 4'h0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_value", 32'(value_a), 32'h0);
      check("rst_vv", 32'(vv_a), 32'h0);
      check("rst_locked", 32'(locked_a), 32'h0);
      check("rst_ep", 32'(ep_a), 32'h0);
      check("rst_ec", 32'(ec_a), 32'h0);
      rst = 1'b0;

      // First word after reset (0) is accepted; bounded wait.
      seen = 0;
      for (int t = 0; t < 30 && seen == 0; t++) begin
         @(negedge clk);
         if (vv_a) seen = 1;
      end
      check("first_vv", 32'(seen), 32'h1);
      check("first_value", 32'(value_a), 32'h0);

      // Count 1..15,0,1; lock after the 9th accepted value.
      acc = 1;
      cur = 4'h0;
      for (int k = 0; k < 17; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
         acc++;
         check("cnt_lat", 32'(lat), 32'd7);
         check("cnt_nvv", 32'(nvv), 32'd1);
         check("cnt_value", 32'(value_a), 32'(cur));
         check("cnt_locked", 32'(locked_a), (acc >= 9) ? 32'h1 : 32'h0);
      end
      check("cnt_ec", 32'(ec_a), 32'h0);

      // Glitch to F for 2 cycles between 5 and 6.
      for (int k = 0; k < 4; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
      end
      check("pre_glitch_value", 32'(value_a), 32'h5);
      pin = 4'hF;
      nvv = 0; nep = 0;
      repeat (2) begin
         @(negedge clk);
         if (vv_a) nvv++;
         if (ep_a) nep++;
      end
      pin = 4'h6;
      repeat (10) begin
         @(negedge clk);
         if (vv_a) nvv++;
         if (ep_a) nep++;
      end
      cur = 4'h6;
      check("glitch_nvv", 32'(nvv), 32'd1);
      check("glitch_nep", 32'(nep), 32'd0);
      check("glitch_value", 32'(value_a), 32'h6);
      check("glitch_locked", 32'(locked_a), 32'h1);

      // Skip 6 -> 8: one error, lock lost, 8 good increments relock.
      cur = 4'h8;
      step(cur, lat, nvv, nep);
      check("skip_nep", 32'(nep), 32'd1);
      check("skip_ec", 32'(ec_a), 32'd1);
      check("skip_locked", 32'(locked_a), 32'h0);
      check("skip_value", 32'(value_a), 32'h8);
      for (int k = 1; k <= 8; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
         check("relock_locked", 32'(locked_a), (k == 8) ? 32'h1 : 32'h0);
      end
      check("relock_value", 32'(value_a), 32'h0);

      // Hold 0 for 70 cycles: timeout on the 64th idle enabled cycle.
      nep = 0; ep_tick = 0;
      for (int t = 1; t <= 70; t++) begin
         @(negedge clk);
         if (ep_a) begin
            nep++;
            if (ep_tick == 0) ep_tick = t;
         end
      end
      check("to_nep", 32'(nep), 32'd1);
      check("to_tick", 32'(ep_tick), 32'(lat + 64 - 10));
      check("to_ec", 32'(ec_a), 32'd2);
      check("to_locked", 32'(locked_a), 32'h0);
      for (int k = 1; k <= 9; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
         check("hunt_nvv", 32'(nvv), 32'd1);
         check("hunt_locked", 32'(locked_a), (k == 9) ? 32'h1 : 32'h0);
      end

      // Five skip errors, relocking after each.
      for (int e = 0; e < 5; e++) begin
         cur = cur + 4'h2;
         step(cur, lat, nvv, nep);
         check("sat_nep", 32'(nep), 32'd1);
         for (int k = 0; k < 8; k++) begin
            cur = cur + 4'h1;
            step(cur, lat, nvv, nep);
         end
         check("sat_locked", 32'(locked_a), 32'h1);
      end
      check("sat_ec_a", 32'(ec_a), 32'd7);
      check("sat_ec_b", 32'(ec_b), 32'd3);
      check("sat_locked_b", 32'(locked_b), 32'h1);

      // clr_err on the same cycle as an error: clear wins, pulse still shows.
      cur = cur + 4'h2;
      pin = cur;
      repeat (6) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      check("clr_ep_a", 32'(ep_a), 32'h1);
      check("clr_ep_b", 32'(ep_b), 32'h1);
      check("clr_vv_b", 32'(vv_b), 32'h1);
      check("clr_ec_a", 32'(ec_a), 32'h0);
      check("clr_ec_b", 32'(ec_b), 32'h0);
      clr_err = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
      end
      check("clr_relock", 32'(locked_a), 32'h1);

      // ena low for 100 cycles while the input moves: everything frozen.
      ena = 1'b0;
      pin = cur + 4'h1;
      nvv = 0; nep = 0;
      repeat (100) begin
         @(negedge clk);
         if (vv_a) nvv++;
         if (ep_a) nep++;
      end
      check("ena_nvv", 32'(nvv), 32'd0);
      check("ena_nep", 32'(nep), 32'd0);
      check("ena_locked", 32'(locked_a), 32'h1);
      check("ena_value", 32'(value_a), 32'(cur));
      ena = 1'b1;
      cur = cur + 4'h1;
      step(cur, lat, nvv, nep);
      check("ena_resume_nvv", 32'(nvv), 32'd1);
      check("ena_resume_nep", 32'(nep), 32'd0);
      check("ena_resume_value", 32'(value_a), 32'(cur));
      check("ena_resume_locked", 32'(locked_a), 32'h1);

      // Reset mid-lock, then a full relock is required.
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_value", 32'(value_a), 32'h0);
      check("mid_rst_locked", 32'(locked_a), 32'h0);
      check("mid_rst_vv", 32'(vv_a), 32'h0);
      check("mid_rst_ep", 32'(ep_a), 32'h0);
      check("mid_rst_value_b", 32'(value_b), 32'h0);
      rst = 1'b0;
      nvv = 0;
      repeat (12) begin
         @(negedge clk);
         if (vv_a) nvv++;
      end
      check("post_rst_nvv", 32'(nvv), 32'd1);
      check("post_rst_value", 32'(value_a), 32'(cur));
      check("post_rst_locked", 32'(locked_a), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         cur = cur + 4'h1;
         step(cur, lat, nvv, nep);
         check("post_rst_relock", 32'(locked_a), (k == 8) ? 32'h1 : 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
